// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the two-key debouncer:
//   - state_t : per-key debounce FSM states
//   - DEFAULT_DEBOUNCE_CYCLES / DEFAULT_LONG_CYCLES : 1 ms / 1 s at 50 MHz
//   - max_int : helper used to size the stability counters
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int DEFAULT_LONG_CYCLES     = 50000000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// ---------------------------------------------------------------------------
// key_debounce_if
// Bundles the raw key inputs and all debounced / stopwatch-control outputs.
//   KEY         : raw push-buttons, active-low, asynchronous
//   key_level   : debounced key state, 1 = pressed
//   key_press   : one-cycle pulse per accepted press
//   key_release : one-cycle pulse per accepted release
//   key_long    : one-cycle long-press pulse
//   run_flag    : stopwatch run/stop state, 1 = counting
//   clr_pulse   : one-cycle stopwatch clear request
// Modports:
//   master : the side that owns the buttons and consumes the results
//   slave  : the debouncer itself
// ---------------------------------------------------------------------------
interface key_debounce_if;

  logic [1:0] KEY;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] key_long;
  logic       run_flag;
  logic       clr_pulse;

  modport master (
    output KEY,
    input  key_level, key_press, key_release, key_long, run_flag, clr_pulse
  );

  modport slave (
    input  KEY,
    output key_level, key_press, key_release, key_long, run_flag, clr_pulse
  );

endinterface

// File: rtl/key_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch
// Debounces a single active-low push-button.
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   raw_key     : raw button, active-low, asynchronous
//   level       : registered debounced state, 1 = pressed
//   press       : registered one-cycle pulse on accepted press
//   rel         : registered one-cycle pulse on accepted release
//   long_pulse  : registered one-cycle long-press pulse
//   press_early : combinational press decision, one cycle ahead of 'press',
//                 so the parent can register its own reaction in step with it
// Optional feature macro: KEY_LONG_PRESS_EN (long-press detection). When it
// is undefined long_pulse is tied to 0 and no long-press logic exists.
// DEBOUNCE_CYCLES is expected to be at least 2.
// ---------------------------------------------------------------------------
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_key,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_pulse,
  output logic press_early
);

  // One spare bit on top of the largest count so saturation never aliases
  // onto a compare value.
  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LONG_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             sampled;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             press_d;
  logic             rel_d;
  logic             level_d;

  // Two-flop synchronizer; reset value is the released (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= raw_key;
      sync_b <= sync_a;
    end
  end

  assign sampled = ~sync_b;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  // State register; outputs are registered here from the output decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_d;
      press <= press_d;
      rel   <= rel_d;
    end
  end

  // Next-state logic. Counters restart at 0 on every entry to a wait state
  // and a change is accepted once the incremented count reaches DEB_LAST.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (sampled) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sampled) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_inc >= DEB_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        if (!sampled) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end else begin
`ifdef KEY_LONG_PRESS_EN
          cnt_next = cnt_inc;
`else
          cnt_next = '0;
`endif
        end
      end
      RELEASE_WAIT: begin
        if (sampled) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_inc >= DEB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode: pulses fire only on a completed debounce, never when a
  // wait state falls back because of a bounce.
  always_comb begin
    press_d = (state == PRESS_WAIT) && (state_next == PRESSED);
    rel_d   = (state == RELEASE_WAIT) && (state_next == IDLE);
    level_d = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

  assign press_early = press_d;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic long_d;
  logic long_done;

  // long_done blocks a second pulse when a release bounce sends the FSM
  // back into PRESSED and restarts the counter within the same press.
  assign long_d = (state == PRESSED) && sampled && !long_done && (cnt_inc == LONG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      long_pulse <= 1'b0;
      long_done  <= 1'b0;
    end else begin
      long_pulse <= long_d;
      if (press_d) begin
        long_done <= 1'b0;
      end else if (long_d) begin
        long_done <= 1'b1;
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Two-key debouncer driving a stopwatch: KEY[0] toggles run/stop, KEY[1]
// requests a counter clear while the stopwatch is stopped.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   RESET    : synchronous active-high reset
//   bus      : key_debounce_if.slave (KEY in; key_level, key_press,
//              key_release, key_long, run_flag, clr_pulse out)
// Optional feature macro: KEY_LONG_PRESS_EN (key_long pulses after a key has
// been held LONG_CYCLES; otherwise key_long is constant 0).
// ---------------------------------------------------------------------------
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  key_debounce_if.slave bus
);

  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] rel;
  logic [1:0] long_pulse;
  logic [1:0] press_early;
  logic       run_flag;
  logic       clr_pulse;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk         (CLOCK_50),
      .rst         (RESET),
      .raw_key     (bus.KEY[i]),
      .level       (level[i]),
      .press       (press[i]),
      .rel         (rel[i]),
      .long_pulse  (long_pulse[i]),
      .press_early (press_early[i])
    );
  end

  // Driven from the early press decision so run_flag and clr_pulse change on
  // the same edge key_press rises. The clear looks at run_flag before the
  // toggle, so a simultaneous start+clear from stopped still clears.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      run_flag  <= 1'b0;
      clr_pulse <= 1'b0;
    end else begin
      clr_pulse <= press_early[1] & ~run_flag;
      run_flag  <= run_flag ^ press_early[0];
    end
  end

  assign bus.key_level   = level;
  assign bus.key_press   = press;
  assign bus.key_release = rel;
  assign bus.key_long    = long_pulse;
  assign bus.run_flag    = run_flag;
  assign bus.clr_pulse   = clr_pulse;

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive stable synchronized samples needed to accept a key change (1 ms at 50 MHz).
REQ-002 Parameter LONG_CYCLES, default 50000000, is the number of cycles a key must stay accepted-pressed before a long-press pulse (1 s at 50 MHz).
REQ-003 CLOCK_50  input  1  system clock; all logic is on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 KEY  input  2  raw push-buttons, active-low, asynchronous to CLOCK_50, bouncing.
REQ-006 key_level  output  2  debounced key state, 1 = pressed.
REQ-007 key_press  output  2  one-cycle pulse on each accepted press.
REQ-008 key_release  output  2  one-cycle pulse on each accepted release.
REQ-009 run_flag  output  1  stopwatch run/stop state; 1 = counting.
REQ-010 clr_pulse  output  1  one-cycle counter-clear request to the stopwatch.
REQ-011 key_long  output  2  one-cycle long-press pulse (see Configuration).

Function
REQ-012 Each KEY bit shall pass through a two-flop synchronizer and be inverted to active-high before any other use.
REQ-013 Each channel shall run an independent FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE: synchronized pressed -> PRESS_WAIT with the stability counter cleared to 0.
REQ-015 PRESS_WAIT: sample released -> IDLE (no pulse); otherwise increment; on reaching DEBOUNCE_CYCLES-1 -> PRESSED.
REQ-016 PRESSED: sample released -> RELEASE_WAIT with counter cleared; otherwise continue.
REQ-017 RELEASE_WAIT: sample pressed -> PRESSED (no pulse); otherwise increment; on reaching DEBOUNCE_CYCLES-1 -> IDLE.
REQ-018 key_level shall be 1 in PRESSED and RELEASE_WAIT and 0 otherwise; all outputs are registered.
REQ-019 With KEY stable from edge N, key_press/key_release shall be high exactly in the cycle after edge N+2+DEBOUNCE_CYCLES-1, for one cycle.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES samples shall produce no pulse and no key_level change.
REQ-021 key_press[0] shall toggle run_flag in the same cycle key_press[0] is asserted.
REQ-022 clr_pulse shall assert for one cycle when key_press[1] is asserted while run_flag is 0; key_press[1] while running is ignored.
REQ-023 Simultaneous key_press[0] and key_press[1] with run_flag 0: run_flag becomes 1 and clr_pulse also asserts (clear evaluated on pre-toggle state).
REQ-024 Stability counters shall be $clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES))+1 bits wide and saturate, never wrap.

Reset
REQ-025 RESET high at a clock edge shall force all FSMs to IDLE, counters to 0, synchronizer flops to released, and key_level, key_press, key_release, key_long, clr_pulse, run_flag to 0.
REQ-026 A key held through reset release shall be accepted as a new press after the normal debounce latency.
REQ-027 Reset mid-debounce shall discard the partial count with no pulse emitted.

Configuration
REQ-028 Macro KEY_LONG_PRESS_EN defined: in PRESSED the counter runs from 0 and key_long pulses once when it reaches LONG_CYCLES-1; no repeat until the next press.
REQ-029 Macro KEY_LONG_PRESS_EN undefined: key_long port present, tied to 0, no long-press counter logic synthesized.

Structure
REQ-030 Package key_pkg shall hold the FSM state typedef (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the default cycle constants.
REQ-031 One sub-module key_debounce_ch shall implement synchronizer, FSM and counters for a single key; key_debounce instantiates two and adds run/clear logic.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-032 KEY[0] 1->0 stable -> key_press[0] pulse 6 cycles later, key_level[0]=1, run_flag 0->1.
REQ-033 KEY[0] low for 2 cycles then high -> no key_press, key_level[0] stays 0.
REQ-034 run_flag=0, press KEY[1] -> clr_pulse one cycle; repeat with run_flag=1 -> no clr_pulse.
REQ-035 Hold KEY[1] 30 cycles with macro defined -> exactly one key_long[1] pulse; macro undefined -> key_long stays 0.
REQ-036 RESET asserted 2 cycles into PRESS_WAIT and while run_flag=1 -> all outputs 0 next cycle, no pulse later until fresh debounce completes.
